// File: rtl/ham_pkg.sv
// Shared types and the SECDED encode function for the Hamming encode engine.
// Codeword layout: {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
package ham_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StCap,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    localparam int unsigned BYTES_PER_WORD  = 2;
    localparam int unsigned CYCLES_PER_WORD = 5;

    function automatic logic [15:0] ham_encode11(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^{d[11:8], d[4:2]};
        p2 = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
        p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
        // Overall parity covers the data bits and all four check bits.
        p0 = ^{d, p8, p4, p2, p1};
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/ham_encode_engine_if.sv
// Byte-wide data memory port shared between the core and the encode engine.
// The engine drives it as master; the memory model is the slave.
interface ham_encode_engine_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/ham_enc11.sv
// Combinational 11-bit to 16-bit SECDED encoder.
module ham_enc11
    import ham_pkg::*;
(
    input  logic [11:1] d_i,
    output logic [15:0] cw_o
);

    assign cw_o = ham_encode11(d_i);

endmodule

// File: rtl/ham_encode_engine.sv
// Reads NUM_WORDS 11-bit messages as byte pairs, encodes each to a 16-bit SECDED codeword
// and writes it back as a byte pair; owns the memory port only while busy.
module ham_encode_engine
    import ham_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 15,
    parameter int unsigned SRC_BASE   = 0,
    parameter int unsigned DST_BASE   = 30,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned AUTO_START = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    output logic                done,
    output logic                busy,
    ham_encode_engine_if.master mem
);

    localparam int unsigned IdxW = $clog2(NUM_WORDS + 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [2:0]        hi_q, hi_d;
    logic              auto_q, auto_d;
    logic [15:0]       cw;
    logic [ADDR_W-1:0] src_addr, dst_addr, addr_c;
    logic [7:0]        wdata_c;
    logic              we_c, last_word;

    ham_enc11 u_enc (
        .d_i  ({hi_q, lo_q}),
        .cw_o (cw)
    );

    // Address arithmetic wraps modulo 2^ADDR_W through the casts.
    assign src_addr  = ADDR_W'(SRC_BASE + idx_q * BYTES_PER_WORD);
    assign dst_addr  = ADDR_W'(DST_BASE + idx_q * BYTES_PER_WORD);
    assign last_word = (idx_q == IdxW'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            auto_q  <= (AUTO_START != 0);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        auto_d  = auto_q;
        addr_c  = '0;
        wdata_c = '0;
        we_c    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (init || auto_q) begin
                    state_d = StRdLo;
                    idx_d   = '0;
                    auto_d  = 1'b0;
                end
            end
            StRdLo: begin
                addr_c  = src_addr;
                state_d = StRdHi;
            end
            StRdHi: begin
                addr_c  = src_addr + ADDR_W'(1);
                lo_d    = mem.mem_rdata;
                state_d = StCap;
            end
            StCap: begin
                hi_d    = mem.mem_rdata[2:0];
                state_d = StWrLo;
            end
            StWrLo: begin
                we_c    = 1'b1;
                addr_c  = dst_addr;
                wdata_c = cw[7:0];
                state_d = StWrHi;
            end
            StWrHi: begin
                we_c    = 1'b1;
                addr_c  = dst_addr + ADDR_W'(1);
                wdata_c = cw[15:8];
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StRdLo;
                end
            end
            StDone: begin
                if (init) begin
                    state_d = StRdLo;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A reset cycle must never commit a write, even from WR_LO/WR_HI.
    assign mem.mem_we    = we_c & ~reset;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;
    assign done          = (state_q == StDone);
    assign busy          = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_ham_encode_engine.sv
// Directed bench for ham_encode_engine: memory model, positional Hamming reference model,
// write scoreboard checked on every write cycle, plus literal codeword expectations.
module tb_ham_encode_engine;

    logic clk = 1'b0;
    logic reset;
    logic init;
    logic done;
    logic busy;
    logic ld_all;
    logic [10:0] enc_v;
    logic [15:0] enc_cw;

    logic [7:0] mem [256];
    logic [7:0] img [256];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    ham_encode_engine_if #(.ADDR_W(8)) bus ();

    ham_encode_engine #(
        .NUM_WORDS  (15),
        .SRC_BASE   (0),
        .DST_BASE   (30),
        .ADDR_W     (8),
        .AUTO_START (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .done  (done),
        .busy  (busy),
        .mem   (bus.master)
    );

    ham_enc11 u_enc (
        .d_i  (enc_v),
        .cw_o (enc_cw)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; ld_all copies the staged image in.
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (ld_all) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: data fills the non-power-of-two positions 1..15 in ascending order,
    // parity at position 2^b covers every position with bit b set, bit 0 is overall parity.
    function automatic logic [15:0] model_cw(input logic [10:0] v);
        logic [15:0] cw;
        int k;
        int pb;
        logic p;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = v[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            pb = 1 << b;
            p  = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (pos != pb && (pos & pb) != 0) p = p ^ cw[pos];
            end
            cw[pb] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic push_expected();
        logic [10:0] v;
        logic [15:0] cw;
        for (int w = 0; w < 15; w++) begin
            v  = {img[2*w+1][2:0], img[2*w]};
            cw = model_cw(v);
            exp_q.push_back('{a: 8'(30 + 2*w), d: cw[7:0]});
            exp_q.push_back('{a: 8'(31 + 2*w), d: cw[15:8]});
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        ld_all = 1'b1;
        @(posedge clk);
        #1;
        ld_all = 1'b0;
    endtask

    task automatic fill_img();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    endtask

    // Starts a run and counts edges from the init-sampling edge until done.
    task automatic run_job(input int pulse_lo, input int pulse_hi, output int cycles);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check("start busy", 32'(busy), 32'd1);
        check("start done", 32'(done), 32'd0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            init = (cycles >= pulse_lo && cycles <= pulse_hi);
            @(posedge clk);
            #1;
            cycles++;
        end
        @(negedge clk);
        init = 1'b0;
    endtask

    // Scoreboard: every write cycle must match the next expected (addr, data).
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            check("we only while busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected write: addr %0h data %0h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write addr", 32'(bus.mem_addr), 32'(e.a));
                check("write data", 32'(bus.mem_wdata), 32'(e.d));
            end
        end
    end

    logic [10:0] lit_d  [4] = '{11'h000, 11'h001, 11'h400, 11'h7FF};
    logic [15:0] lit_cw [4] = '{16'h0000, 16'h000F, 16'h8117, 16'hFFFF};

    initial begin
        int cyc;
        int bad;
        reset  = 1'b1;
        init   = 1'b0;
        ld_all = 1'b0;
        enc_v  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset we", 32'(bus.mem_we), 32'd0);
        check("reset addr", 32'(bus.mem_addr), 32'd0);
        check("reset wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle without init", 32'(busy), 32'd0);

        // Standalone encoder: literal pins, then random vectors against the model.
        for (int i = 0; i < 4; i++) begin
            enc_v = lit_d[i];
            #1;
            check("enc11 literal", 32'(enc_cw), 32'(lit_cw[i]));
        end
        for (int i = 0; i < 8; i++) begin
            enc_v = 11'($urandom);
            #1;
            check("enc11 random", 32'(enc_cw), 32'(model_cw(enc_v)));
        end

        // Zero word, all-ones word, all-ones with ignored hi bits set, rest random.
        fill_img();
        img[0] = 8'h00; img[1] = 8'h00;
        img[2] = 8'hFF; img[3] = 8'h07;
        img[4] = 8'hFF; img[5] = 8'hFF;
        load_mem();
        push_expected();
        run_job(-1, -1, cyc);
        check("latency random run", 32'(cyc), 32'd75);
        check("all writes seen", 32'(exp_q.size()), 32'd0);
        check("zero lo", 32'(mem[30]), 32'h00);
        check("zero hi", 32'(mem[31]), 32'h00);
        check("ones lo", 32'(mem[32]), 32'hFF);
        check("ones hi", 32'(mem[33]), 32'hFF);
        check("ones ignored lo", 32'(mem[34]), 32'hFF);
        check("ones ignored hi", 32'(mem[35]), 32'hFF);
        bad = 0;
        for (int i = 0; i < 30; i++) if (mem[i] !== img[i]) bad++;
        for (int i = 60; i < 256; i++) if (mem[i] !== img[i]) bad++;
        check("bytes outside 30..59 untouched", 32'(bad), 32'd0);

        // Single-bit messages in the first and last word slots.
        fill_img();
        img[0]  = 8'h01; img[1]  = 8'h00;
        img[28] = 8'h00; img[29] = 8'h04;
        load_mem();
        push_expected();
        run_job(-1, -1, cyc);
        check("latency edge words", 32'(cyc), 32'd75);
        check("word0 lo", 32'(mem[30]), 32'h0F);
        check("word0 hi", 32'(mem[31]), 32'h00);
        check("word14 lo", 32'(mem[58]), 32'h17);
        check("word14 hi", 32'(mem[59]), 32'h81);

        // Reset in the middle of a run aborts at once.
        fill_img();
        load_mem();
        push_expected();
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", 32'(done), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        fill_img();
        load_mem();
        push_expected();
        run_job(-1, -1, cyc);
        check("latency after abort", 32'(cyc), 32'd75);
        check("writes after abort", 32'(exp_q.size()), 32'd0);

        // init held for a few cycles while busy must not restart the run.
        fill_img();
        load_mem();
        push_expected();
        run_job(10, 12, cyc);
        check("latency with init while busy", 32'(cyc), 32'd75);
        check("writes with init while busy", 32'(exp_q.size()), 32'd0);

        // init in DONE re-runs with identical output.
        push_expected();
        run_job(-1, -1, cyc);
        check("latency rerun from done", 32'(cyc), 32'd75);
        check("writes rerun from done", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
